// File: rtl/game_ctrl.sv
// Flappy-style game controller: flap synchronizer/debouncer, play-state FSM, scoring.
// Define GAME_CTRL_HIGH_SCORE_EN to keep a session best_score; otherwise best_score is 0.
module game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SCORE_W         = 8,
  parameter int unsigned DEATH_FRAMES    = 30,
  parameter int unsigned LOCKOUT_FRAMES  = 60
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               flap,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               pipe_passed,
  output logic               flap_pulse,
  output logic               game_start,
  output logic               playing,
  output logic               game_over,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FrzW = $clog2(DEATH_FRAMES + 1);
  localparam int unsigned LckW = $clog2(LOCKOUT_FRAMES + 1);

  localparam logic [DbW-1:0]     DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FrzW-1:0]    FrzInit  = FrzW'(DEATH_FRAMES);
  localparam logic [LckW-1:0]    LckInit  = LckW'(LOCKOUT_FRAMES);
  localparam logic [SCORE_W-1:0] ScoreMax = '1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPlaying = 2'd1,
    StDying   = 2'd2,
    StOver    = 2'd3
  } state_e;

  logic           flap_meta_q, flap_sync_q;
  logic           db_level_q, db_prev_q, flap_pulse_q;
  logic [DbW-1:0] db_cnt_q;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      flap_meta_q  <= 1'b0;
      flap_sync_q  <= 1'b0;
      db_level_q   <= 1'b0;
      db_prev_q    <= 1'b0;
      flap_pulse_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      flap_meta_q  <= flap;
      flap_sync_q  <= flap_meta_q;
      db_prev_q    <= db_level_q;
      flap_pulse_q <= db_level_q & ~db_prev_q;
      if (flap_sync_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_level_q <= flap_sync_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  state_e            state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [FrzW-1:0]   freeze_q, freeze_d;
  logic [LckW-1:0]   lock_q, lock_d;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [SCORE_W-1:0] best_q, best_d;
`endif

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    freeze_d = freeze_q;
    lock_d   = lock_q;
`ifdef GAME_CTRL_HIGH_SCORE_EN
    best_d   = best_q;
`endif
    unique case (state_q)
      StIdle: begin
        score_d = '0;
        if (flap_pulse_q) state_d = StPlaying;
      end
      StPlaying: begin
        // Collision takes priority over a simultaneous pipe_passed.
        if (collision) begin
          state_d  = StDying;
          freeze_d = FrzInit;
        end else if (pipe_passed && (score_q != ScoreMax)) begin
          score_d = score_q + 1'b1;
        end
      end
      StDying: begin
        if (frame_tick) begin
          freeze_d = freeze_q - 1'b1;
          if (freeze_q <= FrzW'(1)) begin
            state_d = StOver;
            lock_d  = LckInit;
`ifdef GAME_CTRL_HIGH_SCORE_EN
            if (score_q > best_q) best_d = score_q;
`endif
          end
        end
      end
      StOver: begin
        if (frame_tick && (lock_q != '0)) lock_d = lock_q - 1'b1;
        if (flap_pulse_q && (lock_q == '0)) begin
          state_d = StIdle;
          score_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      score_q  <= '0;
      freeze_q <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      freeze_q <= freeze_d;
      lock_q   <= lock_d;
    end
  end

`ifdef GAME_CTRL_HIGH_SCORE_EN
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) best_q <= '0;
    else       best_q <= best_d;
  end
  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

  assign flap_pulse = flap_pulse_q;
  assign state      = state_q;
  assign score      = score_q;
  assign game_start = (state_q != StIdle);
  assign playing    = (state_q == StPlaying);
  assign game_over  = (state_q == StOver);

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: behavioural model compared every cycle plus directed checks.
module tb_game_ctrl;

  localparam int D  = 4;
  localparam int SW = 4;
  localparam int DF = 2;
  localparam int LF = 3;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  logic          clk_100MHz = 1'b0;
  logic          reset;
  logic          flap = 1'b0, frame_tick = 1'b0, collision = 1'b0, pipe_passed = 1'b0;
  logic          flap_pulse, game_start, playing, game_over;
  logic [1:0]    state;
  logic [SW-1:0] score, best_score;

  game_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SCORE_W        (SW),
    .DEATH_FRAMES   (DF),
    .LOCKOUT_FRAMES (LF)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .flap       (flap),
    .frame_tick (frame_tick),
    .collision  (collision),
    .pipe_passed(pipe_passed),
    .flap_pulse (flap_pulse),
    .game_start (game_start),
    .playing    (playing),
    .game_over  (game_over),
    .state      (state),
    .score      (score),
    .best_score (best_score)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: flap samples newest-first; the level flips when the D samples that have
  // already crossed the two sync stages all disagree with it.
  int m_state = 0, m_score = 0, m_best = 0, m_freeze = 0, m_lock = 0;
  bit m_level = 0, m_level_prev = 0, m_pulse = 0;
  bit hist[$];

  always @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      m_state = 0; m_score = 0; m_best = 0; m_freeze = 0; m_lock = 0;
      m_level = 0; m_level_prev = 0; m_pulse = 0;
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    end else begin
      case (m_state)
        0: if (m_pulse) m_state = 1;
        1: begin
          if (collision) begin
            m_state = 2; m_freeze = DF;
          end else if (pipe_passed && m_score < (1 << SW) - 1) begin
            m_score++;
          end
        end
        2: if (frame_tick) begin
          m_freeze--;
          if (m_freeze == 0) begin
            m_state = 3; m_lock = LF;
            if (HsEn && m_score > m_best) m_best = m_score;
          end
        end
        default: begin
          if (m_pulse && m_lock == 0) begin
            m_state = 0; m_score = 0;
          end else if (frame_tick && m_lock > 0) begin
            m_lock--;
          end
        end
      endcase
      hist.push_front(flap);
      void'(hist.pop_back());
      m_pulse = m_level && !m_level_prev;
      m_level_prev = m_level;
      begin
        bit flip;
        flip = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (hist[k] == m_level) flip = 1'b0;
        if (flip) m_level = !m_level;
      end
    end
  end

  always @(negedge clk_100MHz) begin
    chk("state", int'(state), m_state);
    chk("score", int'(score), m_score);
    chk("best_score", int'(best_score), m_best);
    chk("flap_pulse", int'(flap_pulse), int'(m_pulse));
    chk("game_start", int'(game_start), int'(m_state != 0));
    chk("playing", int'(playing), int'(m_state == 1));
    chk("game_over", int'(game_over), int'(m_state == 3));
    if (flap_pulse) pulse_cnt++;
  end

  task automatic step();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic do_flap();
    flap = 1'b1;
    repeat (8) step();
    flap = 1'b0;
    repeat (8) step();
  endtask

  task automatic pipe();
    pipe_passed = 1'b1;
    step();
    pipe_passed = 1'b0;
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic crash();
    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
  endtask

  int pc0;

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_state", int'(state), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_flap_pulse", int'(flap_pulse), 0);

    // 3-clock glitch never debounces.
    flap = 1'b1;
    repeat (3) step();
    flap = 1'b0;
    repeat (10) step();
    chk("glitch_no_pulse", pulse_cnt, 0);
    chk("glitch_idle", int'(state), 0);

    // Clean rise: pulse exactly 6 clocks after the first high sample.
    flap = 1'b1;
    step();
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 6) chk("flap_pulse_timing", int'(flap_pulse), (i == 6) ? 1 : 0);
    end
    chk("start_state", int'(state), 1);
    chk("start_game_start", int'(game_start), 1);
    flap = 1'b0;
    repeat (8) step();
    chk("single_pulse", pulse_cnt, 1);

    // Game A: score 7.
    repeat (7) pipe();
    chk("gameA_score", int'(score), 7);
    crash();
    chk("gameA_dying", int'(state), 2);
    tick();
    chk("gameA_dying_tick1", int'(state), 2);
    tick();
    chk("gameA_over", int'(state), 3);
    chk("gameA_best", int'(best_score), HsEn ? 7 : 0);
    repeat (3) tick();
    do_flap();
    chk("gameA_idle", int'(state), 0);

    // Game B: collision and pipe_passed together at score 5.
    do_flap();
    chk("gameB_playing", int'(state), 1);
    repeat (5) pipe();
    collision = 1'b1;
    pipe_passed = 1'b1;
    step();
    collision = 1'b0;
    pipe_passed = 1'b0;
    chk("coll_wins_score", int'(score), 5);
    chk("coll_wins_state", int'(state), 2);
    tick();
    do_flap();
    chk("dying_ignores_flap", int'(state), 2);
    tick();
    chk("over_at_tick2", int'(state), 3);
    tick();
    tick();
    do_flap();
    chk("lockout_holds", int'(state), 3);
    tick();
    do_flap();
    chk("restart_state", int'(state), 0);
    chk("restart_score", int'(score), 0);
    chk("gameB_best", int'(best_score), HsEn ? 7 : 0);

    // Game C: asynchronous reset mid-game at score 9, flap held through release.
    do_flap();
    repeat (9) pipe();
    chk("gameC_score", int'(score), 9);
    reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_score", int'(score), 0);
    chk("async_playing", int'(playing), 0);
    chk("async_best", int'(best_score), 0);
    flap = 1'b1;
    repeat (3) step();
    pc0 = pulse_cnt;
    reset = 1'b0;
    repeat (12) step();
    chk("held_flap_one_pulse", pulse_cnt - pc0, 1);
    chk("held_flap_playing", int'(state), 1);
    flap = 1'b0;
    repeat (8) step();

    // Game D: saturation.
    repeat (17) pipe();
    chk("saturate_score", int'(score), 15);
    crash();
    tick();
    tick();
    chk("gameD_over", int'(state), 3);
    chk("gameD_best", int'(best_score), HsEn ? 15 : 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
